// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory responder: FSM states and
// fixed widths used by the responder and its storage array.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = 4;
    localparam int BE_W  = 4;

    // Low address bits that must be zero for a word access.
    localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/dmem_word_array.sv
// Word-organised data storage: one synchronous write port with per-byte
// enables and a registered read port. Contents are never reset.
module dmem_word_array
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            rd_en,
    input  logic [BE_W-1:0] we,
    input  logic [AW-1:0]   addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: no reset on the array or its read register; resetting a RAM
    // prevents block-RAM mapping, and stored data must survive rst anyway.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rdata <= mem[addr];
        end
        for (int i = 0; i < BE_W; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-port responder for the MIPS CPU: valid/ready request, programmable
// wait cycles, then a response held until the CPU accepts it.
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    input  logic [BE_W-1:0] req_be,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [31:0]     resp_rdata,
    output logic            resp_err
);

    localparam int unsigned AW           = $clog2(DEPTH_WORDS);
    localparam logic [31:0] WINDOW_BYTES = 32'(DEPTH_WORDS * 4);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               wr_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [BE_W-1:0]    be_q;

    logic               accept;
    logic               access;
    logic               acc_write;
    logic [31:0]        acc_addr;
    logic [31:0]        acc_wdata;
    logic [BE_W-1:0]    acc_be;
    logic               acc_err;
    logic [AW-1:0]      acc_idx;
    logic               rsp_err;
    logic               mem_rd_en;
    logic [BE_W-1:0]    mem_we;
    logic [31:0]        mem_rdata;

    function automatic logic addr_err(input logic [31:0] a);
        return ((a & ALIGN_MASK) != 32'd0) || (a < BASE_ADDR) ||
               ((a - BASE_ADDR) >= WINDOW_BYTES);
    endfunction

    // The storage access happens on the RESP-entry edge: straight from the
    // request inputs when LATENCY is 0, otherwise from the captured request
    // on the last WAIT edge. Read data is registered into the response one
    // edge later.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        accept    = (state == IDLE) && req_valid && req_ready;
        access    = 1'b0;
        acc_write = wr_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        if (accept && (LATENCY == 0)) begin
            access    = 1'b1;
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else if ((state == WAIT) && (cnt == CNT_W'(1))) begin
            access = 1'b1;
        end
    end

    assign acc_err   = addr_err(acc_addr);
    assign acc_idx   = AW'((acc_addr - BASE_ADDR) >> 2);
    assign mem_rd_en = access && !acc_err && !acc_write;
    assign mem_we    = (access && !acc_err && acc_write) ? acc_be : '0;
    assign rsp_err   = addr_err(addr_q);

    dmem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .rd_en (mem_rd_en),
        .we    (mem_we),
        .addr  (acc_idx),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!req_ready) begin
                        req_ready <= 1'b1;
                    end else if (accept) begin
                        wr_q      <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        be_q      <= req_be;
                        req_ready <= 1'b0;
                        cnt       <= CNT_W'(LATENCY);
                        state     <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    // First RESP cycle collects the registered read data.
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                        resp_err   <= rsp_err;
                        resp_rdata <= (wr_q || rsp_err) ? 32'd0 : mem_rdata;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench for mips_dmem_responder: one instance at LATENCY=2 and one
// at LATENCY=0, sharing request data and reset, selected by sel.
module tb_mips_dmem_responder;

    localparam int LAT = 2;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic        wr;
        int          idx;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_ready;
    logic        sel;

    logic        rv2, rr2, vv2, er2;
    logic        rv0, rr0, vv0, er0;
    logic [31:0] rd2, rd0;

    logic        cur_req_ready, cur_resp_valid, cur_resp_err;
    logic [31:0] cur_resp_rdata;

    logic [31:0] model_mem [2][256];
    exp_t        exp_q [$];
    exp_t        last_e;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    assign rv2 = req_valid && !sel;
    assign rv0 = req_valid && sel;
    assign cur_req_ready  = sel ? rr0 : rr2;
    assign cur_resp_valid = sel ? vv0 : vv2;
    assign cur_resp_err   = sel ? er0 : er2;
    assign cur_resp_rdata = sel ? rd0 : rd2;

    mips_dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(rv2), .req_ready(rr2), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(vv2), .resp_ready(resp_ready), .resp_rdata(rd2), .resp_err(er2)
    );

    mips_dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(rv0), .req_ready(rr0), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(vv0), .resp_ready(resp_ready), .resp_rdata(rd0), .resp_err(er0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h0000_0400);
    endfunction

    task automatic apply_store(input exp_t e);
        for (int i = 0; i < 4; i++) begin
            if (e.be[i]) model_mem[sel][e.idx][8*i +: 8] = e.wdata[8*i +: 8];
        end
    endtask

    // Waits for req_ready, presents one request and returns just after the
    // accepting edge.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!cur_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before_send", {31'd0, cur_req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        e.err   = model_err(a);
        e.wr    = w;
        e.idx   = int'(a[9:2]);
        e.wdata = d;
        e.be    = be;
        e.rdata = (w || e.err) ? 32'd0 : model_mem[sel][e.idx];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Waits for resp_valid, checks latency and payload against the scoreboard.
    task automatic receive();
        int lat = 0;
        while (!cur_resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("resp_latency", 32'(lat), sel ? 32'd1 : 32'(LAT + 1));
        if (exp_q.size() == 0) begin
            check("scoreboard_depth", 32'(exp_q.size()), 32'd1);
        end else begin
            last_e = exp_q.pop_front();
            check("resp_err", {31'd0, cur_resp_err}, {31'd0, last_e.err});
            check("resp_rdata", cur_resp_rdata, last_e.rdata);
            if (last_e.wr && !last_e.err) apply_store(last_e);
        end
    endtask

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
        send(w, a, d, be);
        receive();
        @(posedge clk);
        #1;
        check("resp_valid_cleared", {31'd0, cur_resp_valid}, 32'd0);
        check("resp_rdata_cleared", cur_resp_rdata, 32'd0);
        check("req_ready_after_resp", {31'd0, cur_req_ready}, 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"}, {31'd0, cur_req_ready}, 32'd0);
        check({tag, "_resp_valid"}, {31'd0, cur_resp_valid}, 32'd0);
        check({tag, "_resp_rdata"}, cur_resp_rdata, 32'd0);
        check({tag, "_resp_err"}, {31'd0, cur_resp_err}, 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("req_ready_before_first_edge", {31'd0, cur_req_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("req_ready_after_release", {31'd0, cur_req_ready}, 32'd1);
    endtask

    // Asserts reset shortly after an accept; the pending store commits only
    // when its RESP-entry edge has already happened.
    task automatic abort_after_send(input bit committed);
        exp_t e;
        #1;
        rst = 1'b0;
        #1;
        check_outputs_zero("async_abort");
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (committed && e.wr && !e.err) apply_store(e);
        end
        release_reset();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_be     = '0;
        resp_ready = 1'b1;
        sel        = 1'b0;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset_l2");
        sel = 1'b1;
        #1;
        check_outputs_zero("reset_l0");
        sel = 1'b0;
        release_reset();
        check("req_ready_l0_after_release", {31'd0, rr0}, 32'd1);

        // Full store then load, partial store, errors, empty byte mask.
        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        txn(1'b0, 32'h10, 32'h0, 4'h0);
        txn(1'b1, 32'h10, 32'h0000_1200, 4'b0010);
        txn(1'b0, 32'h10, 32'h0, 4'h0);
        txn(1'b0, 32'h13, 32'h0, 4'hF);
        txn(1'b1, 32'h400, 32'h5555_5555, 4'hF);
        txn(1'b1, 32'h12, 32'h6666_6666, 4'hF);
        txn(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0);
        txn(1'b0, 32'h10, 32'h0, 4'h0);
        check("partial_store_value", last_e.rdata, 32'hDEAD_12EF);

        // Backpressure with a spurious request arriving during RESP.
        resp_ready = 1'b0;
        send(1'b0, 32'h10, 32'h0, 4'h0);
        receive();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = 32'h10;
                req_wdata = 32'h0;
                req_be    = 4'hF;
            end
            check("bp_resp_valid", {31'd0, cur_resp_valid}, 32'd1);
            check("bp_resp_rdata", cur_resp_rdata, 32'hDEAD_12EF);
            check("bp_resp_err", {31'd0, cur_resp_err}, 32'd0);
            check("bp_req_ready", {31'd0, cur_req_ready}, 32'd0);
        end
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_released_valid", {31'd0, cur_resp_valid}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("bp_spurious_ignored", {31'd0, cur_req_ready}, 32'd1);
        txn(1'b0, 32'h10, 32'h0, 4'h0);

        // Reset during WAIT of a store: the store must not commit.
        txn(1'b1, 32'h20, 32'h1111_1111, 4'hF);
        send(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
        abort_after_send(1'b0);
        txn(1'b0, 32'h20, 32'h0, 4'h0);
        check("abort_store_value", last_e.rdata, 32'h1111_1111);

        // Reset while a response is being held clears it immediately.
        resp_ready = 1'b0;
        send(1'b0, 32'h10, 32'h0, 4'h0);
        receive();
        #2;
        rst = 1'b0;
        #1;
        check_outputs_zero("async_resp");
        resp_ready = 1'b1;
        release_reset();

        // Short random store/load mix in a scratch region.
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(16, 31)) << 2;
            txn(1'b1, a, $urandom, 4'hF);
            txn(1'b1, a, $urandom, 4'($urandom_range(0, 15)));
            txn(1'b0, a, 32'h0, 4'h0);
        end

        // Zero-latency instance: one-cycle response, and a store whose
        // access edge precedes reset is kept.
        sel = 1'b1;
        txn(1'b1, 32'h30, 32'h0BAD_F00D, 4'hF);
        txn(1'b0, 32'h30, 32'h0, 4'h0);
        txn(1'b0, 32'h31, 32'h0, 4'h0);
        send(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
        abort_after_send(1'b1);
        txn(1'b0, 32'h20, 32'h0, 4'h0);
        check("l0_committed_value", last_e.rdata, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
